control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multicycle MIPS-subset control FSM.
// Drives datapath selects, memory strobes and PC/IR/regfile enables per state.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        stall,
  input  logic        OUTLSB,
  input  logic        waitrequest,
  output logic        PcEn,
  output logic        IorD,
  output logic        IrWrite,
  output logic        IrSel,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtSel,
  output logic [3:0]  ALUControl,
  output logic        ALUsel,
  output logic        PCSrc,
  output logic        read,
  output logic        write,
  output logic        active
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_EQ    = 4'b0110;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  state_t state, nxt;

  logic [5:0] op;
  logic [5:0] fn;
  logic is_r, is_jr, is_addiu, is_sltiu;
  logic is_andi, is_ori, is_xori;
  logic is_lw, is_sw, is_beq, is_bne;
  logic is_ialu, is_br, supported;
  logic go, taken;
  logic unused_ok;

  assign op = Instr[31:26];
  assign fn = Instr[5:0];
  assign unused_ok = ^Instr[25:6];

  assign is_r     = (op == 6'h00);
  assign is_jr    = is_r && (fn == 6'h08);
  assign is_addiu = (op == 6'h09);
  assign is_sltiu = (op == 6'h0B);
  assign is_andi  = (op == 6'h0C);
  assign is_ori   = (op == 6'h0D);
  assign is_xori  = (op == 6'h0E);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);

  assign is_ialu = is_addiu | is_sltiu | is_andi | is_ori | is_xori;
  assign is_br   = is_beq | is_bne;
  assign supported = is_r | is_ialu | is_lw | is_sw | is_br;

  // PC/regfile commits wait until neither memory nor ALU is busy
  assign go    = ~waitrequest & ~stall;
  assign taken = is_beq ? OUTLSB : ~OUTLSB;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    PcEn       = 1'b0;
    IorD       = 1'b0;
    IrWrite    = 1'b0;
    IrSel      = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtSel     = 1'b0;
    ALUControl = ALU_ADD;
    ALUsel     = 1'b0;
    PCSrc      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    active     = 1'b1;
    if (reset) begin
      nxt = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          read    = 1'b1;
          ALUSrcB = 2'b01;
          if (go) begin
            IrWrite = 1'b1;
            PcEn    = 1'b1;
            nxt     = DECODE;
          end
        end
        DECODE: begin
          IrSel   = 1'b1;
          ALUSrcB = 2'b11;
          nxt     = supported ? EXEC : HALT;
        end
        EXEC: begin
          IrSel   = 1'b1;
          ALUSrcA = 1'b1;
          if (is_r) begin
            if (is_jr) begin
              if (go) begin
                PcEn = 1'b1;
                nxt  = FETCH;
              end
            end else begin
              ALUControl = ALU_FUNCT;
              if (!stall) nxt = WB;
            end
          end else if (is_ialu) begin
            ALUSrcB = 2'b10;
            ExtSel  = is_andi | is_ori | is_xori;
            unique case (1'b1)
              is_sltiu: ALUControl = ALU_SLTU;
              is_andi:  ALUControl = ALU_AND;
              is_ori:   ALUControl = ALU_OR;
              is_xori:  ALUControl = ALU_XOR;
              default:  ALUControl = ALU_ADD;
            endcase
            nxt = WB;
          end else if (is_lw | is_sw) begin
            ALUSrcB = 2'b10;
            nxt     = MEM;
          end else if (is_br) begin
            ALUControl = ALU_EQ;
            if (go) begin
              if (taken) begin
                PcEn   = 1'b1;
                ALUsel = 1'b1;
              end
              nxt = FETCH;
            end
          end else begin
            nxt = HALT;
          end
        end
        MEM: begin
          IrSel  = 1'b1;
          IorD   = 1'b1;
          ALUsel = 1'b1;
          if (is_lw) begin
            read = 1'b1;
            if (go) begin
              RegWrite = 1'b1;
              nxt      = FETCH;
            end
          end else if (is_sw) begin
            // strobe stays up for the whole stalled access
            write = 1'b1;
            if (!waitrequest) nxt = FETCH;
          end else begin
            nxt = HALT;
          end
        end
        WB: begin
          IrSel    = 1'b1;
          MemToReg = 1'b1;
          ALUsel   = 1'b1;
          RegDst   = is_r;
          if (go) begin
            RegWrite = 1'b1;
            nxt      = FETCH;
          end
        end
        HALT: begin
          active = 1'b0;
        end
        default: begin
          nxt = FETCH;
        end
      endcase
    end
  end

endmodule
